// File: rtl/keypad_scanner_gen.sv
// Matrix keypad scanner: one-hot column drive, 2-flop row sync, debounce, ghost reject, event FIFO.
// Latency: row edge to FIFO push <= 2 + SCAN_CYCLES + DEBOUNCE_CYCLES + 1 clk; evt_valid one clk after push.
// Backpressure: evt_valid/evt_ready; events arriving while the FIFO is full are dropped with an overflow pulse.
// Optional: define KEYPAD_RELEASE_EVT_EN to also queue a release event after each accepted press.
module keypad_scanner_gen #(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int DEBOUNCE_CYCLES = 2400000,
    parameter int SCAN_CYCLES     = 4,
    parameter int FIFO_DEPTH      = 4,
    localparam int CODE_W         = $clog2(NROWS * NCOLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NROWS-1:0]  row,
    output logic [NCOLS-1:0]  col,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic              evt_release,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int DW_W   = $clog2(SCAN_CYCLES);
    localparam int CIDX_W = $clog2(NCOLS);
    localparam int RIDX_W = $clog2(NROWS);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIDX_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESS    = 3'd2,
        HOLD     = 3'd3,
        REL_DEB  = 3'd4
    } state_t;

    // Synchroniser and scan state
    logic [NROWS-1:0]  row_meta;
    logic [NROWS-1:0]  rs;
    state_t            state, state_n;
    logic [DW_W-1:0]   dwell_cnt, dwell_n;
    logic [CNT_W-1:0]  deb_cnt, deb_n;
    logic [CIDX_W-1:0] col_idx, col_idx_n;
    logic [NROWS-1:0]  rlat, rlat_n;
    logic [CIDX_W-1:0] clat, clat_n;

    // Event generation
    logic              rlat_onehot;
    logic [RIDX_W-1:0] row_idx;
    logic [CODE_W-1:0] push_code;
    logic              push;
    logic              push_rel;

    // Event FIFO (shift-register style: entry 0 is always the head)
    logic [CODE_W-1:0] fifo_code [FIFO_DEPTH];
    logic [CODE_W-1:0] code_n    [FIFO_DEPTH];
`ifdef KEYPAD_RELEASE_EVT_EN
    logic              fifo_rel  [FIFO_DEPTH];
    logic              rel_n     [FIFO_DEPTH];
`endif
    logic [FCNT_W-1:0] fifo_cnt, cnt_n;
    logic [FIDX_W-1:0] wr_idx;
    logic              fifo_full;
    logic              pop;
    logic              ovf_n;

    // Two-flop synchroniser for the asynchronous row returns
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= '0;
            rs       <= '0;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    assign col         = NCOLS'(1) << col_idx;
    assign busy        = (state != SCAN);
    assign rlat_onehot = $onehot(rlat);
    assign push_code   = CODE_W'(int'(row_idx) * NCOLS + int'(clat));

    // Row index of the latched (one-hot) row pattern
    always_comb begin
        row_idx = '0;
        for (int i = 0; i < NROWS; i++) begin
            if (rlat[i]) row_idx = RIDX_W'(i);
        end
    end

    // Scan FSM state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            col_idx   <= '0;
            rlat      <= '0;
            clat      <= '0;
        end else begin
            state     <= state_n;
            dwell_cnt <= dwell_n;
            deb_cnt   <= deb_n;
            col_idx   <= col_idx_n;
            rlat      <= rlat_n;
            clat      <= clat_n;
        end
    end

    // Scan FSM next state: column dwell, press debounce, hold, release debounce
    always_comb begin
        state_n   = state;
        dwell_n   = dwell_cnt;
        deb_n     = deb_cnt;
        col_idx_n = col_idx;
        rlat_n    = rlat;
        clat_n    = clat;
        push      = 1'b0;
        push_rel  = 1'b0;
        case (state)
            SCAN: begin
                if (dwell_cnt == DW_W'(SCAN_CYCLES - 1)) begin
                    dwell_n = '0;
                    if (rs == '0) begin
                        col_idx_n = (col_idx == CIDX_W'(NCOLS - 1)) ? '0 : col_idx + 1'b1;
                    end else begin
                        rlat_n  = rs;
                        clat_n  = col_idx;
                        deb_n   = '0;
                        state_n = DEBOUNCE;
                    end
                end else begin
                    dwell_n = dwell_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs != rlat) begin
                    // Row pattern changed before settling: resume scanning this column
                    state_n = SCAN;
                    dwell_n = '0;
                end else if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    // Multi-key patterns are ghost-prone: wait for release without an event
                    state_n = rlat_onehot ? PRESS : HOLD;
                end else begin
                    deb_n = deb_cnt + 1'b1;
                end
            end
            PRESS: begin
                push    = 1'b1;
                state_n = HOLD;
            end
            HOLD: begin
                if (rs == '0) begin
                    deb_n   = '0;
                    state_n = REL_DEB;
                end
            end
            REL_DEB: begin
                if (rs != '0) begin
                    state_n = HOLD;
                end else if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = SCAN;
                    dwell_n = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
                    push     = rlat_onehot;
                    push_rel = 1'b1;
`endif
                end else begin
                    deb_n = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_n = SCAN;
                dwell_n = '0;
            end
        endcase
    end

    assign evt_valid = (fifo_cnt != '0);
    assign fifo_full = (fifo_cnt == FCNT_W'(FIFO_DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign evt_code  = fifo_code[0];
`ifdef KEYPAD_RELEASE_EVT_EN
    assign evt_release = fifo_rel[0];
`else
    assign evt_release = 1'b0;
`endif

    // FIFO next contents: pop shifts toward the head, push lands behind the last valid entry
    always_comb begin
        code_n = fifo_code;
`ifdef KEYPAD_RELEASE_EVT_EN
        rel_n  = fifo_rel;
`endif
        cnt_n  = fifo_cnt;
        ovf_n  = 1'b0;
        wr_idx = '0;
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                code_n[i] = fifo_code[i+1];
`ifdef KEYPAD_RELEASE_EVT_EN
                rel_n[i]  = fifo_rel[i+1];
`endif
            end
            code_n[FIFO_DEPTH-1] = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
            rel_n[FIFO_DEPTH-1]  = 1'b0;
`endif
            cnt_n = fifo_cnt - 1'b1;
        end
        if (push) begin
            if (pop || !fifo_full) begin
                wr_idx = pop ? FIDX_W'(fifo_cnt - 1'b1) : FIDX_W'(fifo_cnt);
                code_n[wr_idx] = push_code;
`ifdef KEYPAD_RELEASE_EVT_EN
                rel_n[wr_idx]  = push_rel;
`endif
                cnt_n = pop ? fifo_cnt : fifo_cnt + 1'b1;
            end else begin
                ovf_n = 1'b1;
            end
        end
    end

    // FIFO storage, occupancy and overflow pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_code[i] <= '0;
`ifdef KEYPAD_RELEASE_EVT_EN
                fifo_rel[i]  <= 1'b0;
`endif
            end
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            fifo_code <= code_n;
`ifdef KEYPAD_RELEASE_EVT_EN
            fifo_rel  <= rel_n;
`endif
            fifo_cnt  <= cnt_n;
            overflow  <= ovf_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner_gen.sv
// Bench for keypad_scanner_gen: emulates a physical key matrix driven by the DUT columns,
// predicts the event stream from key-level rules (one event per clean press, none for ghosts),
// and compares popped events, overflow pulses and status outputs.
module tb_keypad_scanner_gen;

    localparam int NR    = 4;
    localparam int NC    = 4;
    localparam int DEB   = 8;
    localparam int SCN   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [3:0] evt_code;
    logic       evt_release;
    logic       overflow;
    logic       busy;

    keypad_scanner_gen #(
        .NROWS(NR), .NCOLS(NC), .DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCN), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_release(evt_release), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Key matrix: kd[c][r] = key at (row r, column c) is held down
    logic [3:0] kd [4];
    always_comb begin
        row = '0;
        for (int c = 0; c < NC; c++) begin
            if (col[c]) row = row | kd[c];
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_q[$];
    logic [4:0] got_q[$];
    int         got_cyc[$];
    int         cmp_idx = 0;
    int         exp_ovf = 0;
    int         ovf_seen = 0;
    bit         rand_ready = 1'b0;

    // Consumer side: record every accepted event and every overflow pulse
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            got_q.push_back({evt_release, evt_code});
            got_cyc.push_back(cyc);
        end
        if (!reset && overflow) ovf_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
    endtask

    // Reference FIFO occupancy = predicted events not yet consumed
    function automatic void model_push(input logic [3:0] code, input logic rel);
        if (exp_q.size() - got_q.size() >= DEPTH) exp_ovf++;
        else exp_q.push_back({rel, code});
    endfunction

    task automatic compare_events(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = cmp_idx; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_event"}, got_q[i], exp_q[i]);
        cmp_idx = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    endtask

    task automatic drain(input string tag);
        evt_ready = 1'b1;
        for (int i = 0; i < 60 && evt_valid; i++) tick();
        check({tag, "_drained"}, evt_valid, 0);
    endtask

    // Press keys 'rows' in column c (optionally bouncing), hold, release, then predict events
    task automatic do_press(input int c, input logic [3:0] rows, input bit bounce, input string tag);
        int idx;
        int stable_cyc;
        int r_idx;
        int nb;
        if (bounce) begin
            nb = $urandom_range(2, 4);
            for (int b = 0; b < nb; b++) begin
                kd[c] = rows;
                repeat ($urandom_range(1, 3)) tick();
                kd[c] = '0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        kd[c] = rows;
        stable_cyc = cyc;
        repeat (40) tick();
        check({tag, "_hold_busy"}, busy, 1);
        if (bounce) begin
            nb = $urandom_range(2, 4);
            for (int b = 0; b < nb; b++) begin
                kd[c] = '0;
                repeat ($urandom_range(1, 3)) tick();
                kd[c] = rows;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        kd[c] = '0;
        repeat (30) tick();
        check({tag, "_idle_busy"}, busy, 0);
        idx = exp_q.size();
        if ($onehot(rows)) begin
            r_idx = 0;
            for (int r = 0; r < NR; r++) if (rows[r]) r_idx = r;
            model_push(4'(r_idx * NC + c), 1'b0);
`ifdef KEYPAD_RELEASE_EVT_EN
            model_push(4'(r_idx * NC + c), 1'b1);
`endif
            if (bounce && got_cyc.size() > idx)
                check({tag, "_settle"}, 32'(got_cyc[idx] - stable_cyc >= DEB), 1);
        end
    endtask

    initial begin
        int         c;
        logic [3:0] rows;
        bit         bn;
        int         r1;
        int         r2;
        int         w;

        for (int i = 0; i < NC; i++) kd[i] = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_col", col, 1);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_rel", evt_release, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);

        // Idle scan: each column held SCN clocks, wrapping
        for (int n = 1; n < 32; n++) begin
            tick();
            check("scan_col", col, 32'(1 << ((n / SCN) % NC)));
            check("scan_valid", evt_valid, 0);
            check("scan_busy", busy, 0);
        end

        // Clean press, bounced press, ghost pair
        evt_ready = 1'b1;
        do_press(1, 4'b0100, 1'b0, "clean");
        compare_events("clean");
        do_press(1, 4'b0100, 1'b1, "bounce");
        compare_events("bounce");
        do_press(0, 4'b0101, 1'b0, "ghost");
        compare_events("ghost");

        // Random keys, bounce and consumer backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            c = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                r1   = $urandom_range(0, 3);
                r2   = (r1 + $urandom_range(1, 3)) % NR;
                rows = 4'((1 << r1) | (1 << r2));
                bn   = 1'b0;
            end else begin
                rows = 4'(1 << $urandom_range(0, 3));
                bn   = 1'($urandom_range(0, 1));
            end
            do_press(c, rows, bn, "rand");
        end
        rand_ready = 1'b0;
        drain("rand");
        compare_events("rand");

        // FIFO full: consumer stalled across five distinct presses
        evt_ready = 1'b0;
        do_press(0, 4'b0001, 1'b0, "full0");
        do_press(1, 4'b0010, 1'b0, "full1");
        do_press(2, 4'b0100, 1'b0, "full2");
        do_press(3, 4'b1000, 1'b0, "full3");
        do_press(3, 4'b0001, 1'b0, "full4");
        check("full_valid", evt_valid, 1);
        check("full_head", {evt_release, evt_code}, exp_q[got_q.size()]);
        check("full_ovf", ovf_seen, exp_ovf);
        drain("full");
        compare_events("full");

        // Reset while debouncing with an event still queued
        evt_ready = 1'b0;
        do_press(0, 4'b0010, 1'b0, "rstq");
        check("rstq_valid", evt_valid, 1);
        kd[3] = 4'b0010;
        w = 0;
        while (!busy && w < 40) begin
            tick();
            w++;
        end
        check("rst_reach_deb", busy, 1);
        tick();
        tick();
        reset = 1'b1;
        kd[3] = '0;
        tick();
        reset = 1'b0;
        check("rst2_valid", evt_valid, 0);
        check("rst2_col", col, 1);
        check("rst2_busy", busy, 0);
        check("rst2_code", evt_code, 0);
        while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        repeat (40) tick();
        check("post_rst_valid", evt_valid, 0);
        compare_events("post_rst");
        check("ovf_total", ovf_seen, exp_ovf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
